// File: rtl/atm_digit_entry_pkg.sv
// Shared ATM definitions: entry-FSM state encoding, push-button index map,
// debounce default and BCD digit helpers used by the entry, control and display paths.
package atm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EDIT    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } entry_state_t;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;
  localparam int NUM_BTNS   = 5;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Non-decimal codes are folded back into the 0..9 range.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/atm_digit_entry_if.sv
// Operator-entry bundle: raw buttons and FSM handshake toward the entry block,
// BCD echo, cursor and converted result back to the control FSM and display.
interface atm_digit_entry_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  logic             btn_center;
  logic             entry_start;
  logic             entry_abort;
  logic [VAL_W-1:0] digits;
  logic [CUR_W-1:0] cursor;
  logic             editing;
  logic [VAL_W-1:0] entry_value;
  logic             entry_valid;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center,
    output entry_start, entry_abort,
    input  digits, cursor, editing, entry_value, entry_valid
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center,
    input  entry_start, entry_abort,
    output digits, cursor, editing, entry_value, entry_valid
  );

endinterface

// File: rtl/atm_digit_entry_btn_debounce.sv
// One push-button: 2-flop synchronizer, stable-level counter and a single
// press pulse on the debounced rising edge (no auto-repeat while held).
module btn_debounce
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle back at the accepted level restarts the stability count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/atm_digit_entry.sv
// Operator digit entry: debounced buttons edit a BCD field under a cursor;
// confirm converts it MSD-first to binary and strobes the result to the ATM FSM.
module atm_digit_entry
  import atm_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  atm_digit_entry_if.slave bus
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CUR_W-1:0] CURSOR_MAX = CUR_W'(NUM_DIGITS - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;

  entry_state_t     state_q;
  logic [VAL_W-1:0] digits_q;
  logic [CUR_W-1:0] cursor_q;
  logic [CUR_W-1:0] idx_q;
  logic [VAL_W-1:0] acc_q;
  logic [VAL_W-1:0] entry_value_q;
  logic             entry_valid_q;
  logic             editing_q;

  logic [VAL_W-1:0] digits_up_d;
  logic [VAL_W-1:0] digits_dn_d;
  logic [VAL_W-1:0] acc_d;
  logic [3:0]       conv_digit;

  assign btn_raw[BTN_UP]     = bus.btn_up;
  assign btn_raw[BTN_DOWN]   = bus.btn_down;
  assign btn_raw[BTN_LEFT]   = bus.btn_left;
  assign btn_raw[BTN_RIGHT]  = bus.btn_right;
  assign btn_raw[BTN_CENTER] = bus.btn_center;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_raw[g]),
      .press_o(press[g])
    );
  end

  // Candidate field after up/down on the cursor digit, and the digit being converted.
  always_comb begin
    digits_up_d = digits_q;
    digits_dn_d = digits_q;
    conv_digit  = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CUR_W'(i) == cursor_q) begin
        digits_up_d[i*4 +: 4] = bcd_inc(digits_q[i*4 +: 4]);
        digits_dn_d[i*4 +: 4] = bcd_dec(digits_q[i*4 +: 4]);
      end else begin
        digits_up_d[i*4 +: 4] = digits_q[i*4 +: 4];
        digits_dn_d[i*4 +: 4] = digits_q[i*4 +: 4];
      end
      if (CUR_W'(i) == idx_q) begin
        conv_digit = digits_q[i*4 +: 4];
      end else begin
        conv_digit = conv_digit;
      end
    end
    acc_d = (acc_q * VAL_W'(10)) + VAL_W'(conv_digit);
  end

  // Entry FSM: a restart outranks abort and buttons; one edit action per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      digits_q      <= '0;
      cursor_q      <= CURSOR_MAX;
      idx_q         <= CURSOR_MAX;
      acc_q         <= '0;
      entry_value_q <= '0;
      entry_valid_q <= 1'b0;
      editing_q     <= 1'b0;
    end else begin
      entry_valid_q <= 1'b0;
      if (bus.entry_start) begin
        state_q   <= ST_EDIT;
        digits_q  <= '0;
        cursor_q  <= CURSOR_MAX;
        editing_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_EDIT: begin
            if (bus.entry_abort) begin
              state_q   <= ST_IDLE;
              editing_q <= 1'b0;
            end else if (press[BTN_CENTER]) begin
              state_q <= ST_CONVERT;
              acc_q   <= '0;
              idx_q   <= CURSOR_MAX;
            end else if (press[BTN_UP]) begin
              digits_q <= digits_up_d;
            end else if (press[BTN_DOWN]) begin
              digits_q <= digits_dn_d;
            end else if (press[BTN_LEFT]) begin
              cursor_q <= (cursor_q == CURSOR_MAX) ? cursor_q : cursor_q + CUR_W'(1);
            end else if (press[BTN_RIGHT]) begin
              cursor_q <= (cursor_q == '0) ? cursor_q : cursor_q - CUR_W'(1);
            end else begin
              state_q <= ST_EDIT;
            end
          end
          ST_CONVERT: begin
            if (bus.entry_abort) begin
              state_q   <= ST_IDLE;
              editing_q <= 1'b0;
            end else if (idx_q == '0) begin
              acc_q         <= acc_d;
              entry_value_q <= acc_d;
              entry_valid_q <= 1'b1;
              editing_q     <= 1'b0;
              state_q       <= ST_DONE;
            end else begin
              acc_q <= acc_d;
              idx_q <= idx_q - CUR_W'(1);
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q   <= ST_IDLE;
            editing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.cursor      = cursor_q;
  assign bus.editing     = editing_q;
  assign bus.entry_value = entry_value_q;
  assign bus.entry_valid = entry_valid_q;

endmodule

// File: tb/tb_atm_digit_entry.sv
// Directed bench for atm_digit_entry: table of button/start actions with expected
// field, cursor and editing state, plus sequences for conversion, glitch, abort and reset.
module tb_atm_digit_entry;
  import atm_pkg::*;

  localparam int ND = 4;
  localparam int DB = 4;
  // Raw edge to press pulse is 2 + DB + 1 edges, then NUM_DIGITS + 1 more to the strobe.
  localparam int VALID_EDGE = 2 + DB + 1 + ND + 1;

  typedef enum int {A_START, A_UP, A_DOWN, A_LEFT, A_RIGHT} act_e;

  typedef struct {
    act_e        act;
    logic [15:0] exp_digits;
    logic [1:0]  exp_cursor;
    logic        exp_editing;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   strobes = 0;
  vec_t vecs [0:63];
  int   nv = 0;

  atm_digit_entry_if #(.NUM_DIGITS(ND)) bus ();

  atm_digit_entry #(
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.entry_valid === 1'b1) strobes <= strobes + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input act_e a, input logic [15:0] d, input logic [1:0] c, input logic e);
    vecs[nv].act         = a;
    vecs[nv].exp_digits  = d;
    vecs[nv].exp_cursor  = c;
    vecs[nv].exp_editing = e;
    nv++;
  endtask

  task automatic set_btn(input act_e a, input logic v);
    case (a)
      A_UP:    bus.btn_up    = v;
      A_DOWN:  bus.btn_down  = v;
      A_LEFT:  bus.btn_left  = v;
      A_RIGHT: bus.btn_right = v;
      default: ;
    endcase
  endtask

  task automatic press(input act_e a);
    set_btn(a, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    set_btn(a, 1'b0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.entry_start = 1'b1;
    @(posedge clk);
    #1;
    bus.entry_start = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (vecs[i].act == A_START) pulse_start();
      else press(vecs[i].act);
      chk($sformatf("vec%0d digits", i), 32'(bus.digits), 32'(vecs[i].exp_digits));
      chk($sformatf("vec%0d cursor", i), 32'(bus.cursor), 32'(vecs[i].exp_cursor));
      chk($sformatf("vec%0d editing", i), 32'(bus.editing), 32'(vecs[i].exp_editing));
    end
  endtask

  task automatic center_seq(input logic with_up, input logic [15:0] exp_val,
                            input logic [15:0] exp_digits);
    int first;
    int highs;
    logic [15:0] val_at;
    first = 0;
    highs = 0;
    val_at = 16'h0000;
    bus.btn_center = 1'b1;
    if (with_up) bus.btn_up = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) begin
        bus.btn_center = 1'b0;
        bus.btn_up = 1'b0;
      end
      if (n == VALID_EDGE - 2) chk("editing during convert", 32'(bus.editing), 32'd1);
      if (bus.entry_valid === 1'b1) begin
        highs++;
        if (first == 0) begin
          first = n;
          val_at = bus.entry_value;
        end
      end
    end
    chk("center to valid latency", 32'(first), 32'(VALID_EDGE));
    chk("valid strobe width", 32'(highs), 32'd1);
    chk("entry_value at strobe", 32'(val_at), 32'(exp_val));
    chk("entry_value held", 32'(bus.entry_value), 32'(exp_val));
    chk("digits retained", 32'(bus.digits), 32'(exp_digits));
    chk("editing after done", 32'(bus.editing), 32'd0);
  endtask

  int seg_a, seg_b, seg_c, seg_d, seg_e, seg_end;
  int highs_abort;
  int strobes_before;

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_center = 1'b0;
    bus.entry_start = 1'b0;
    bus.entry_abort = 1'b0;
    rst_n = 1'b0;

    seg_a = nv;
    add(A_START, 16'h0000, 2'd3, 1'b1);
    add(A_UP, 16'h1000, 2'd3, 1'b1);
    add(A_UP, 16'h2000, 2'd3, 1'b1);
    add(A_UP, 16'h3000, 2'd3, 1'b1);
    add(A_RIGHT, 16'h3000, 2'd2, 1'b1);
    add(A_UP, 16'h3100, 2'd2, 1'b1);
    add(A_UP, 16'h3200, 2'd2, 1'b1);
    add(A_UP, 16'h3300, 2'd2, 1'b1);
    add(A_UP, 16'h3400, 2'd2, 1'b1);
    add(A_UP, 16'h3500, 2'd2, 1'b1);
    add(A_UP, 16'h3600, 2'd2, 1'b1);
    add(A_UP, 16'h3700, 2'd2, 1'b1);
    seg_b = nv;
    add(A_START, 16'h0000, 2'd3, 1'b1);
    add(A_DOWN, 16'h9000, 2'd3, 1'b1);
    add(A_UP, 16'h0000, 2'd3, 1'b1);
    add(A_LEFT, 16'h0000, 2'd3, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd2, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd1, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd0, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd0, 1'b1);
    add(A_DOWN, 16'h0009, 2'd0, 1'b1);
    add(A_UP, 16'h0000, 2'd0, 1'b1);
    seg_c = nv;
    add(A_START, 16'h0000, 2'd3, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd2, 1'b1);
    add(A_RIGHT, 16'h0000, 2'd1, 1'b1);
    add(A_UP, 16'h0010, 2'd1, 1'b1);
    add(A_UP, 16'h0020, 2'd1, 1'b1);
    add(A_UP, 16'h0030, 2'd1, 1'b1);
    add(A_UP, 16'h0040, 2'd1, 1'b1);
    add(A_RIGHT, 16'h0040, 2'd0, 1'b1);
    add(A_UP, 16'h0041, 2'd0, 1'b1);
    add(A_UP, 16'h0042, 2'd0, 1'b1);
    seg_d = nv;
    add(A_START, 16'h0000, 2'd3, 1'b1);
    add(A_UP, 16'h1000, 2'd3, 1'b1);
    seg_e = nv;
    add(A_START, 16'h0000, 2'd3, 1'b1);
    add(A_UP, 16'h1000, 2'd3, 1'b1);
    add(A_RIGHT, 16'h1000, 2'd2, 1'b1);
    add(A_UP, 16'h1100, 2'd2, 1'b1);
    add(A_UP, 16'h1200, 2'd2, 1'b1);
    add(A_RIGHT, 16'h1200, 2'd1, 1'b1);
    add(A_UP, 16'h1210, 2'd1, 1'b1);
    add(A_UP, 16'h1220, 2'd1, 1'b1);
    add(A_UP, 16'h1230, 2'd1, 1'b1);
    add(A_RIGHT, 16'h1230, 2'd0, 1'b1);
    add(A_UP, 16'h1231, 2'd0, 1'b1);
    add(A_UP, 16'h1232, 2'd0, 1'b1);
    add(A_UP, 16'h1233, 2'd0, 1'b1);
    add(A_UP, 16'h1234, 2'd0, 1'b1);
    seg_end = nv;

    repeat (3) @(posedge clk);
    #1;
    chk("reset digits", 32'(bus.digits), 32'h0000);
    chk("reset cursor", 32'(bus.cursor), 32'd3);
    chk("reset editing", 32'(bus.editing), 32'd0);
    chk("reset entry_value", 32'(bus.entry_value), 32'd0);
    chk("reset entry_valid", 32'(bus.entry_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Presses while idle must not touch the field.
    press(A_UP);
    chk("idle press ignored", 32'(bus.digits), 32'h0000);

    run_vecs(seg_a, seg_b);
    center_seq(1'b0, 16'd3700, 16'h3700);

    run_vecs(seg_b, seg_c);

    bus.btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.btn_up = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("glitch rejected", 32'(bus.digits), 32'h0000);
    bus.btn_up = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.btn_up = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("long hold one step", 32'(bus.digits), 32'h0001);

    run_vecs(seg_c, seg_d);
    center_seq(1'b1, 16'd42, 16'h0042);

    run_vecs(seg_d, seg_e);
    strobes_before = strobes;
    highs_abort = 0;
    bus.btn_center = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (n == 9) begin
        chk("in convert before abort", 32'(bus.editing), 32'd1);
        bus.entry_abort = 1'b1;
      end
      if (n == 10) begin
        bus.entry_abort = 1'b0;
        bus.btn_center = 1'b0;
        chk("abort to idle", 32'(bus.editing), 32'd0);
      end
      if (bus.entry_valid === 1'b1) highs_abort++;
    end
    chk("abort no strobe", 32'(highs_abort), 32'd0);
    chk("abort strobe count", 32'(strobes), 32'(strobes_before));
    chk("abort keeps entry_value", 32'(bus.entry_value), 32'd42);
    chk("abort keeps digits", 32'(bus.digits), 32'h1000);
    press(A_UP);
    chk("press after abort ignored", 32'(bus.digits), 32'h1000);

    run_vecs(seg_e, seg_end);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid-edit reset digits", 32'(bus.digits), 32'h0000);
    chk("mid-edit reset cursor", 32'(bus.cursor), 32'd3);
    chk("mid-edit reset editing", 32'(bus.editing), 32'd0);
    chk("mid-edit reset entry_value", 32'(bus.entry_value), 32'd0);
    chk("mid-edit reset entry_valid", 32'(bus.entry_valid), 32'd0);
    press(A_UP);
    chk("press after reset ignored", 32'(bus.digits), 32'h0000);
    chk("still idle after reset", 32'(bus.editing), 32'd0);
    pulse_start();
    chk("restart editing", 32'(bus.editing), 32'd1);
    chk("restart cursor", 32'(bus.cursor), 32'd3);

    chk("total strobes", 32'(strobes), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_digit_entry.md
# atm_digit_entry

Operator-input counterpart to the scrolling instruction display: while the display tells the user what to enter, this block collects it. It debounces the five board push-buttons, lets the user edit a fixed-width decimal field digit by digit, and, on confirm, converts the field to binary. It hands the value to the ATM control FSM with a one-cycle valid strobe. The live BCD digits and cursor feed the seven-segment path for echo.

## Interface
Parameters:
- NUM_DIGITS, 4: editable decimal digits; also sets output widths.
- DEBOUNCE_CYCLES, 1_000_000: stable-level cycles required before a button edge is accepted. Benches use 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_center  in  1 each  raw, asynchronous push-buttons, active-high.
- entry_start  in  1  one-cycle pulse from the FSM: clear the field and begin editing.
- entry_abort  in  1  one-cycle pulse: drop the edit and return to IDLE without a strobe.
- digits  out  4*NUM_DIGITS  BCD field; digit 0 is the least significant.
- cursor  out  clog2(NUM_DIGITS)  index of the digit under edit.
- editing  out  1  high in EDIT and CONVERT.
- entry_value  out  4*NUM_DIGITS  binary result. Held until the next entry_start.
- entry_valid  out  1  one-cycle strobe; entry_value is valid in the same cycle.

## Operation
- Per button: a 2-flop synchronizer feeds a saturating counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level. A one-cycle press pulse is generated on the debounced rising edge only, so holding a button never auto-repeats.
- States: IDLE, EDIT, CONVERT, DONE.
- IDLE: press pulses are ignored. entry_start goes to EDIT with digits=0 and cursor=NUM_DIGITS-1.
- EDIT: at most one action per cycle. When several pulses coincide, priority is center > up > down > left > right.
  - up: the digit at cursor increments, 9 wraps to 0.
  - down: the digit decrements, 0 wraps to 9.
  - left: cursor+1, saturates at NUM_DIGITS-1.
  - right: cursor-1, saturates at 0.
  - center: go to CONVERT with acc=0 and index=NUM_DIGITS-1.
- CONVERT: one digit per cycle, most significant first: acc = acc*10 + digits[index]. acc is 4*NUM_DIGITS bits wide; 10^N < 16^N, so it never overflows. After index 0 is processed, load entry_value and go to DONE.
- DONE: assert entry_valid for exactly one cycle, then go to IDLE. digits are retained so the display can keep echoing the entry.
- entry_abort in EDIT or CONVERT: go to IDLE next cycle; digits and entry_value unchanged; no strobe.
- entry_start in any state other than IDLE restarts EDIT with a cleared field. It takes priority over entry_abort and over button actions in the same cycle.
- Button presses in CONVERT, DONE and IDLE are dropped, not queued.

## Timing
- Reset values: digits=0, cursor=NUM_DIGITS-1, editing=0, entry_value=0, entry_valid=0, state=IDLE. Debounce counters and debounced levels reset to 0.
- Raw edge to press pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Digit and cursor updates are visible the cycle after the press pulse.
- Center pulse to entry_valid: NUM_DIGITS+1 cycles (NUM_DIGITS CONVERT cycles, then DONE).
- rst_n low mid-CONVERT: reset values next edge; no strobe.

## Structure
- Shared package atm_pkg holds the state encoding (typedef entry_state_t), BTN_* index constants and the DEBOUNCE_CYCLES default. The ATM control FSM and display path use the same package.
- One sub-module: btn_debounce (synchronizer, counter, rising-edge pulse), instantiated five times.
- BCD edit, conversion and FSM live in atm_digit_entry.

## Test plan
DEBOUNCE_CYCLES=4, NUM_DIGITS=4.
- Reset, then entry_start; pulse up 3 times on digit 3, right, up 7 times, center -> digits=16'h3700, entry_valid exactly 5 cycles after the center pulse, entry_value=3700.
- Down once on a cleared digit, then up once on a 9 -> digit reads 9, then 0 (wrap both ways); left at cursor 3 and right at cursor 0 leave cursor unchanged.
- Raw btn_up glitches high for 3 cycles, then low -> no press pulse, digits unchanged. A 20-cycle hold produces exactly one increment.
- up and center pulses in the same cycle with digits=16'h0042 -> conversion starts, entry_value=42, digit not incremented.
- entry_abort 2 cycles into CONVERT -> no entry_valid, state IDLE, entry_value keeps the previous result.
- rst_n low for 1 cycle mid-EDIT with digits=16'h1234 -> all outputs at reset values; button presses ignored until entry_start.
